// File: rtl/trace_pkg.sv
// Shared constants for the commit trace recorder: flag bit positions, record sizing, FSM states.
package trace_pkg;

   localparam int FLG_REG = 0;
   localparam int FLG_LD  = 1;
   localparam int FLG_ST  = 2;
   localparam int FLG_HLT = 3;

   localparam logic [1:0] ST_TRACE   = 2'd0;
   localparam logic [1:0] ST_HALTED  = 2'd1;
   localparam logic [1:0] ST_TIMEOUT = 2'd2;

   typedef logic [1:0] traceState_t;

   function automatic int recWidth(int dataW, int addrW, int regW, int tsW);
      return 4 + tsW + regW + dataW + addrW + dataW;
   endfunction

   // Record view at the default widths, for consumers decoding ev_data off-chip.
   typedef struct packed {
      logic [3:0]  flags;
      logic [15:0] ts;
      logic [3:0]  writeReg;
      logic [15:0] writeData;
      logic [15:0] memAddr;
      logic [15:0] mdata;
   } traceRec_t;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO with extra-bit pointers; a push into a full FIFO is taken only alongside a pop.
module trace_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic             valid,
   output logic             full,
   output logic [WIDTH-1:0] rdata
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wrPtr;
   logic [AW:0]      rdPtr;
   logic             doPush;
   logic             doPop;

   assign valid  = (wrPtr != rdPtr);
   assign full   = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
   assign doPop  = pop && valid;
   assign doPush = push && (!full || doPop);
   assign rdata  = valid ? mem[rdPtr[AW-1:0]] : '0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wrPtr <= '0;
         rdPtr <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + 1'b1;
         if (doPop)  rdPtr <= rdPtr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (doPush) mem[wrPtr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/commit_trace_buf.sv
// Commit-event recorder: packs each event cycle into a timestamped record and queues it for a
// valid/ready drain port, with cycle/instruction counters, halt capture and a watchdog.
module commit_trace_buf
   import trace_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int ADDR_W     = 16,
   parameter int REG_W      = 4,
   parameter int DEPTH      = 16,
   parameter int CNT_W      = 32,
   parameter int TS_W       = 16,
   parameter int MAX_CYCLES = 100000,
   localparam int REC_W     = recWidth(DATA_W, ADDR_W, REG_W, TS_W)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              reg_write,
   input  logic [REG_W-1:0]  write_reg,
   input  logic [DATA_W-1:0] write_data,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              halt,
   output logic              ev_valid,
   input  logic              ev_ready,
   output logic [REC_W-1:0]  ev_data,
   output logic [CNT_W-1:0]  cycle_count,
   output logic [CNT_W-1:0]  inst_count,
   output logic [CNT_W-1:0]  drop_count,
   output logic              overflow,
   output logic              done,
   output logic              timeout
);

   typedef struct packed {
      logic [3:0]        flags;
      logic [TS_W-1:0]   ts;
      logic [REG_W-1:0]  writeReg;
      logic [DATA_W-1:0] writeData;
      logic [ADDR_W-1:0] memAddr;
      logic [DATA_W-1:0] mdata;
   } rec_t;

   traceState_t state;
   traceState_t stateNext;
   rec_t        rec;
   logic        active;
   logic        pushReq;
   logic        popReq;
   logic        fifoFull;
   logic        drop;

   assign done    = (state == ST_HALTED);
   assign timeout = (state == ST_TIMEOUT);
   assign active  = en && (state == ST_TRACE);
   assign pushReq = active && (reg_write || mem_read || mem_write || halt);
   assign popReq  = ev_valid && ev_ready;
   // A pop in the same cycle frees the slot, so only a push without a pop is lost.
   assign drop    = pushReq && fifoFull && !popReq;

   always_comb begin
      rec                 = '0;
      rec.flags[FLG_REG]  = reg_write;
      rec.flags[FLG_LD]   = mem_read;
      rec.flags[FLG_ST]   = mem_write;
      rec.flags[FLG_HLT]  = halt;
      rec.ts              = cycle_count[TS_W-1:0];
      if (reg_write) begin
         rec.writeReg  = write_reg;
         rec.writeData = write_data;
      end
      if (mem_read || mem_write) begin
         rec.memAddr = mem_addr;
         rec.mdata   = mem_write ? mem_wdata : mem_rdata;
      end
   end

   // Halt outranks the watchdog when both land on the same cycle.
   always_comb begin
      stateNext = state;
      if (active) begin
         if (halt) begin
            stateNext = ST_HALTED;
         end else if (cycle_count == CNT_W'(MAX_CYCLES - 1)) begin
            stateNext = ST_TIMEOUT;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= ST_TRACE;
         cycle_count <= '0;
         inst_count  <= '0;
         drop_count  <= '0;
         overflow    <= 1'b0;
      end else begin
         state <= stateNext;
         if (active) begin
            cycle_count <= cycle_count + CNT_W'(1);
            if (halt || reg_write || mem_write) inst_count <= inst_count + CNT_W'(1);
         end
         if (drop) begin
            overflow <= 1'b1;
            if (drop_count != '1) drop_count <= drop_count + CNT_W'(1);
         end
      end
   end

   trace_fifo #(
      .WIDTH (REC_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (pushReq),
      .wdata (rec),
      .pop   (popReq),
      .valid (ev_valid),
      .full  (fifoFull),
      .rdata (ev_data)
   );

endmodule

// File: tb/tb_commit_trace_buf.sv
// Directed bench for commit_trace_buf: single-cycle vector table plus multi-cycle sequences.
module tb_commit_trace_buf;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic        reg_write;
   logic [3:0]  write_reg;
   logic [15:0] write_data;
   logic        mem_read;
   logic        mem_write;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        halt;
   logic        ev_valid;
   logic        ev_ready;
   logic [71:0] ev_data;
   logic [31:0] cycle_count;
   logic [31:0] inst_count;
   logic [31:0] drop_count;
   logic        overflow;
   logic        done;
   logic        timeout;

   int checks = 0;
   int errors = 0;

   commit_trace_buf #(
      .DEPTH      (4),
      .MAX_CYCLES (8)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .reg_write   (reg_write),
      .write_reg   (write_reg),
      .write_data  (write_data),
      .mem_read    (mem_read),
      .mem_write   (mem_write),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .halt        (halt),
      .ev_valid    (ev_valid),
      .ev_ready    (ev_ready),
      .ev_data     (ev_data),
      .cycle_count (cycle_count),
      .inst_count  (inst_count),
      .drop_count  (drop_count),
      .overflow    (overflow),
      .done        (done),
      .timeout     (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        en;
      logic        rw;
      logic [3:0]  wreg;
      logic [15:0] wdata;
      logic        mr;
      logic        mw;
      logic [15:0] maddr;
      logic [15:0] mwdata;
      logic [15:0] mrdata;
      logic        hlt;
      logic        expValid;
      logic [71:0] expRec;
      logic [31:0] expCycle;
      logic [31:0] expInst;
      logic        expDone;
   } vec_t;

   vec_t vecs [8];

   function automatic logic [71:0] mkRec(logic [3:0] flags, logic [15:0] ts, logic [3:0] wreg,
                                         logic [15:0] wdata, logic [15:0] maddr,
                                         logic [15:0] mdata);
      return {flags, ts, wreg, wdata, maddr, mdata};
   endfunction

   task automatic chkBit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chkCnt(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chkRec(input string name, input logic [71:0] act, input logic [71:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      reg_write  = 1'b0;
      write_reg  = '0;
      write_data = '0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      mem_rdata  = '0;
      halt       = 1'b0;
   endtask

   task automatic doReset();
      idle();
      en       = 1'b1;
      ev_ready = 1'b0;
      rst_n    = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   task automatic regWrite(input logic [3:0] r, input logic [15:0] d);
      idle();
      reg_write  = 1'b1;
      write_reg  = r;
      write_data = d;
   endtask

   initial begin
      vecs[0] = '{1'b1, 1'b1, 4'd3, 16'h1234, 1'b0, 1'b0, 16'h5555, 16'h6666, 16'h7777, 1'b0,
                  1'b1, mkRec(4'b0001, 16'd0, 4'd3, 16'h1234, 16'h0000, 16'h0000), 32'd1, 32'd1,
                  1'b0};
      vecs[1] = '{1'b1, 1'b0, 4'd5, 16'h9999, 1'b0, 1'b1, 16'h0040, 16'hBEEF, 16'h1111, 1'b0,
                  1'b1, mkRec(4'b0100, 16'd0, 4'd0, 16'h0000, 16'h0040, 16'hBEEF), 32'd1, 32'd1,
                  1'b0};
      vecs[2] = '{1'b1, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 16'h0010, 16'h2222, 16'h00AA, 1'b0,
                  1'b1, mkRec(4'b0010, 16'd0, 4'd0, 16'h0000, 16'h0010, 16'h00AA), 32'd1, 32'd0,
                  1'b0};
      vecs[3] = '{1'b1, 1'b1, 4'd7, 16'h00AA, 1'b1, 1'b0, 16'h0010, 16'h0000, 16'h00AA, 1'b0,
                  1'b1, mkRec(4'b0011, 16'd0, 4'd7, 16'h00AA, 16'h0010, 16'h00AA), 32'd1, 32'd1,
                  1'b0};
      vecs[4] = '{1'b1, 1'b0, 4'd2, 16'h3333, 1'b0, 1'b0, 16'h4444, 16'h5555, 16'h6666, 1'b1,
                  1'b1, mkRec(4'b1000, 16'd0, 4'd0, 16'h0000, 16'h0000, 16'h0000), 32'd1, 32'd1,
                  1'b1};
      vecs[5] = '{1'b1, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0,
                  1'b0, 72'd0, 32'd1, 32'd0, 1'b0};
      vecs[6] = '{1'b0, 1'b1, 4'd3, 16'h1234, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0,
                  1'b0, 72'd0, 32'd0, 32'd0, 1'b0};
      vecs[7] = '{1'b1, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b1, 16'h0080, 16'hCAFE, 16'h0BAD, 1'b0,
                  1'b1, mkRec(4'b0110, 16'd0, 4'd0, 16'h0000, 16'h0080, 16'hCAFE), 32'd1, 32'd1,
                  1'b0};

      // Reset state
      doReset();
      chkBit("rst_valid", ev_valid, 1'b0);
      chkRec("rst_data", ev_data, 72'd0);
      chkCnt("rst_cycle", cycle_count, 32'd0);
      chkCnt("rst_inst", inst_count, 32'd0);
      chkCnt("rst_drop", drop_count, 32'd0);
      chkBit("rst_flags", overflow | done | timeout, 1'b0);

      // Single-cycle vector table
      foreach (vecs[i]) begin
         doReset();
         en         = vecs[i].en;
         reg_write  = vecs[i].rw;
         write_reg  = vecs[i].wreg;
         write_data = vecs[i].wdata;
         mem_read   = vecs[i].mr;
         mem_write  = vecs[i].mw;
         mem_addr   = vecs[i].maddr;
         mem_wdata  = vecs[i].mwdata;
         mem_rdata  = vecs[i].mrdata;
         halt       = vecs[i].hlt;
         step();
         idle();
         en = 1'b1;
         chkBit($sformatf("vec%0d_valid", i), ev_valid, vecs[i].expValid);
         if (vecs[i].expValid) chkRec($sformatf("vec%0d_rec", i), ev_data, vecs[i].expRec);
         chkCnt($sformatf("vec%0d_cycle", i), cycle_count, vecs[i].expCycle);
         chkCnt($sformatf("vec%0d_inst", i), inst_count, vecs[i].expInst);
         chkBit($sformatf("vec%0d_done", i), done, vecs[i].expDone);
      end

      // Register write then store, drained as they arrive
      doReset();
      ev_ready = 1'b1;
      regWrite(4'd3, 16'h1234);
      step();
      chkRec("seq_rw_rec", ev_data, mkRec(4'b0001, 16'd0, 4'd3, 16'h1234, 16'h0, 16'h0));
      idle();
      mem_write = 1'b1;
      mem_addr  = 16'h0040;
      mem_wdata = 16'hBEEF;
      step();
      chkRec("seq_st_rec", ev_data, mkRec(4'b0100, 16'd1, 4'd0, 16'h0, 16'h0040, 16'hBEEF));
      idle();
      step();
      chkBit("seq_rwst_empty", ev_valid, 1'b0);
      chkCnt("seq_rwst_inst", inst_count, 32'd2);

      // Overflow: six writes into four slots, then drain in order
      doReset();
      for (int i = 0; i < 6; i++) begin
         regWrite(4'(i), 16'(i));
         step();
      end
      idle();
      chkCnt("ovf_drop", drop_count, 32'd2);
      chkBit("ovf_flag", overflow, 1'b1);
      chkCnt("ovf_cycle", cycle_count, 32'd6);
      ev_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chkBit($sformatf("ovf_valid%0d", i), ev_valid, 1'b1);
         chkRec($sformatf("ovf_rec%0d", i), ev_data,
                mkRec(4'b0001, 16'(i), 4'(i), 16'(i), 16'h0, 16'h0));
         step();
      end
      chkBit("ovf_drained", ev_valid, 1'b0);
      chkCnt("ovf_drop_hold", drop_count, 32'd2);

      // Full FIFO with a same-cycle pop accepts the push
      doReset();
      for (int i = 0; i < 4; i++) begin
         regWrite(4'(i), 16'(i));
         step();
      end
      regWrite(4'd4, 16'd4);
      ev_ready = 1'b1;
      step();
      idle();
      ev_ready = 1'b0;
      chkCnt("fullpop_drop", drop_count, 32'd0);
      chkBit("fullpop_ovf", overflow, 1'b0);
      chkRec("fullpop_head", ev_data, mkRec(4'b0001, 16'd1, 4'd1, 16'd1, 16'h0, 16'h0));

      // Halt in cycle 5, later writes ignored
      doReset();
      for (int i = 0; i < 5; i++) step();
      halt = 1'b1;
      step();
      idle();
      chkBit("halt_done", done, 1'b1);
      chkCnt("halt_cycle", cycle_count, 32'd6);
      chkCnt("halt_inst", inst_count, 32'd1);
      chkRec("halt_rec", ev_data, mkRec(4'b1000, 16'd5, 4'd0, 16'h0, 16'h0, 16'h0));
      for (int i = 0; i < 3; i++) begin
         regWrite(4'd1, 16'd1);
         step();
      end
      idle();
      chkCnt("halt_cycle_frozen", cycle_count, 32'd6);
      chkCnt("halt_inst_frozen", inst_count, 32'd1);
      ev_ready = 1'b1;
      step();
      ev_ready = 1'b0;
      chkBit("halt_no_more", ev_valid, 1'b0);
      chkBit("halt_no_timeout", timeout, 1'b0);

      // Watchdog at 8 cycles
      doReset();
      ev_ready = 1'b1;
      for (int i = 0; i < 7; i++) step();
      chkBit("wd_before", timeout, 1'b0);
      chkCnt("wd_cycle7", cycle_count, 32'd7);
      step();
      chkBit("wd_fired", timeout, 1'b1);
      chkBit("wd_not_done", done, 1'b0);
      chkCnt("wd_cycle8", cycle_count, 32'd8);
      regWrite(4'd2, 16'h0002);
      step();
      step();
      idle();
      chkCnt("wd_cycle_frozen", cycle_count, 32'd8);
      chkBit("wd_no_push", ev_valid, 1'b0);

      // Halt on the watchdog cycle wins
      doReset();
      for (int i = 0; i < 7; i++) step();
      halt = 1'b1;
      step();
      idle();
      chkBit("wdh_done", done, 1'b1);
      chkBit("wdh_timeout", timeout, 1'b0);
      chkCnt("wdh_cycle", cycle_count, 32'd8);
      chkRec("wdh_rec", ev_data, mkRec(4'b1000, 16'd7, 4'd0, 16'h0, 16'h0, 16'h0));

      // Reset with records buffered
      doReset();
      for (int i = 0; i < 3; i++) begin
         regWrite(4'(i), 16'h00F0);
         step();
      end
      idle();
      chkBit("mid_buffered", ev_valid, 1'b1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chkBit("mid_valid", ev_valid, 1'b0);
      chkCnt("mid_cycle", cycle_count, 32'd0);
      chkCnt("mid_inst", inst_count, 32'd0);
      chkCnt("mid_drop", drop_count, 32'd0);
      chkBit("mid_flags", overflow | done | timeout, 1'b0);
      step();
      chkBit("mid_still_empty", ev_valid, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
